// File: rtl/perceptron_layer_seq.sv
// perceptron_layer_seq
// Time-multiplexed perceptron layer: N_NEU neurons over N_IN signed inputs share a
// single multiply-accumulate unit. Parameters and inputs arrive as a byte-serial
// valid/ready stream; a start pulse runs a sequenced evaluation and results are read
// back through an output selector.
//
// Build option: define PERCEPTRON_RELU_EN for a saturating ReLU relative to the
// threshold; otherwise a step activation (output 0 or 1) is used.
//
// Ports:
//   clk             rising-edge clock
//   rstn            asynchronous active-low reset
//   mode            00 idle, 01 load params, 10 load inputs, 11 run
//   in_valid        data_in valid
//   in_ready        byte accepted when in_valid && in_ready
//   data_in         parameter/input byte
//   start           begin evaluation (mode 11, not busy)
//   busy            evaluation in progress
//   done            one-cycle pulse at end of evaluation
//   out_sel         neuron result select
//   network_outputs y[out_sel], or 0 when out_sel >= N_NEU
module perceptron_layer_seq #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_NEU = 4,
  parameter int unsigned DW    = 8,
  localparam int unsigned ACC_W = 2 * DW + $clog2(N_IN + 1) + 1,
  localparam int unsigned SW    = (N_NEU > 1) ? $clog2(N_NEU) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [1:0]    mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] data_in,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic [SW-1:0] out_sel,
  output logic [DW-1:0] network_outputs
);

  localparam int unsigned NP = N_NEU * (N_IN + 2);
  localparam int unsigned PW = (NP > 1) ? $clog2(NP) : 1;
  localparam int unsigned XW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned NW = SW;

  localparam logic [PW-1:0] P_LAST = PW'(NP - 1);
  localparam logic [XW-1:0] X_LAST = XW'(N_IN - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N_NEU - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_ACT  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] MODE_PAR = 2'b01;
  localparam logic [1:0] MODE_X   = 2'b10;
  localparam logic [1:0] MODE_RUN = 2'b11;

  logic [1:0]              r_mode;
  logic [1:0]              r_state;
  logic [PW-1:0]           r_pptr;
  logic [XW-1:0]           r_xptr;
  logic [NW-1:0]           r_n;
  logic [XW-1:0]           r_i;
  logic signed [ACC_W-1:0] r_acc;
  // Per neuron: N_IN weights, then bias, then threshold (matches the load order).
  logic [DW-1:0]           r_par [NP];
  logic [DW-1:0]           r_x   [N_IN];
  logic [DW-1:0]           r_y   [N_NEU];

  logic                    w_busy;
  logic                    w_accept;
  logic                    w_last;
  logic [PW-1:0]           w_widx;
  logic [PW-1:0]           w_bidx;
  logic [PW-1:0]           w_tidx;
  logic signed [DW-1:0]    w_wgt;
  logic signed [DW-1:0]    w_xin;
  logic signed [2*DW-1:0]  w_mul;
  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_bias;
  logic signed [ACC_W-1:0] w_th;
  logic [DW-1:0]           w_y;
  logic [DW-1:0]           w_out;

  function automatic logic signed [ACC_W-1:0] sext(input logic [DW-1:0] v);
    sext = {{(ACC_W - DW){v[DW-1]}}, v};
  endfunction

  assign w_busy   = (r_state != ST_IDLE);
  assign busy     = w_busy;
  assign done     = (r_state == ST_DONE);
  // Ready follows the registered mode, so it is low out of reset whatever mode reads.
  assign in_ready = !w_busy && ((r_mode == MODE_PAR) || (r_mode == MODE_X));
  assign w_accept = in_valid && in_ready;

  assign w_last = (r_i == X_LAST);
  assign w_widx = PW'(32'(r_n) * (N_IN + 2) + 32'(r_i));
  assign w_bidx = PW'(32'(r_n) * (N_IN + 2) + N_IN);
  assign w_tidx = PW'(32'(r_n) * (N_IN + 2) + N_IN + 1);

  assign w_wgt  = r_par[w_widx];
  assign w_xin  = r_x[r_i];
  assign w_mul  = w_wgt * w_xin;
  assign w_prod = {{(ACC_W - 2 * DW){w_mul[2*DW-1]}}, w_mul};
  // Bias folds into the last MAC step so ACT sees the complete sum.
  assign w_bias = w_last ? sext(r_par[w_bidx]) : '0;
  assign w_th   = sext(r_par[w_tidx]);

`ifdef PERCEPTRON_RELU_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (DW - 1)) - 1);
  logic signed [ACC_W-1:0] w_diff;

  always_comb begin
    w_diff = r_acc - w_th;
    if (w_diff < 0) begin
      w_y = '0;
    end else if (w_diff > Y_MAX) begin
      w_y = Y_MAX[DW-1:0];
    end else begin
      w_y = w_diff[DW-1:0];
    end
  end
`else
  always_comb begin
    w_y    = '0;
    w_y[0] = (r_acc > w_th);
  end
`endif

  always_comb begin
    w_out = '0;
    for (int k = 0; k < N_NEU; k++) begin
      if (32'(out_sel) == 32'(k)) w_out = r_y[k];
    end
  end
  assign network_outputs = w_out;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mode  <= 2'b00;
      r_state <= ST_IDLE;
      r_pptr  <= '0;
      r_xptr  <= '0;
      r_n     <= '0;
      r_i     <= '0;
      r_acc   <= '0;
      r_par   <= '{default: '0};
      r_x     <= '{default: '0};
      r_y     <= '{default: '0};
    end else begin
      // Loading and mode tracking freeze while an evaluation runs.
      if (!w_busy) begin
        if (w_accept && (r_mode == MODE_PAR)) begin
          r_par[r_pptr] <= data_in;
          r_pptr        <= (r_pptr == P_LAST) ? '0 : r_pptr + PW'(1);
        end
        if (w_accept && (r_mode == MODE_X)) begin
          r_x[r_xptr] <= data_in;
          r_xptr      <= (r_xptr == X_LAST) ? '0 : r_xptr + XW'(1);
        end
        // Placed after the writes so a mode change always restarts both pointers.
        if (mode != r_mode) begin
          r_mode <= mode;
          r_pptr <= '0;
          r_xptr <= '0;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (start && (mode == MODE_RUN)) begin
            r_state <= ST_MAC;
            r_acc   <= '0;
            r_n     <= '0;
            r_i     <= '0;
          end
        end
        ST_MAC: begin
          r_acc <= r_acc + w_prod + w_bias;
          if (w_last) begin
            r_state <= ST_ACT;
          end else begin
            r_i <= r_i + XW'(1);
          end
        end
        ST_ACT: begin
          r_y[r_n] <= w_y;
          r_acc    <= '0;
          r_i      <= '0;
          if (r_n == N_LAST) begin
            r_state <= ST_DONE;
          end else begin
            r_n     <= r_n + NW'(1);
            r_state <= ST_MAC;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
